sc_road_scheduler: RTL and testbench
====================================

// Module: sc_road_scheduler
// PURPOSE
//  Game sequencer for the Road Fighter 8x8 LED matrix.
//  - Generates obstacle rows, scrolls them toward the player row at a prescaled rate, and detects crashes.
//  - Raises the level, and with it the scroll speed, as rows are passed.
//  - Outputs feed matrix rows 0..6; row 7 stays the player car from the shift-register path.
// PARAMETERS
//  DATAWIDTH_BUS        8          row width, one bit per LED column
//  PRESCALER_DATAWIDTH  23         scroll prescaler counter width
//  TICK_INIT            5000000    initial scroll period in clocks; must fit PRESCALER_DATAWIDTH
//  TICK_MIN             1000000    minimum scroll period (saturation floor)
//  TICK_STEP            500000     period decrement per level
//  ROWS_PER_LEVEL       16         scroll ticks per level
//  LFSR_SEED            8'hA5      obstacle LFSR reset/restart value; must be non-zero
// PORTS
//  SC_ROADSCHED_CLOCK_50        in   1  system clock, 50 MHz
//  SC_ROADSCHED_RESET_InHigh    in   1  asynchronous reset, active high
//  SC_ROADSCHED_start_In        in   1  debounced start button, active high (level)
//  SC_ROADSCHED_player_InBUS    in   8  player row bitmap (matrix row 7)
//  SC_ROADSCHED_data0..6_OutBUS out  8  obstacle rows; data0 = top row, data6 = row above player
//  SC_ROADSCHED_crash_Out       out  1  high while in CRASH
//  SC_ROADSCHED_state_OutBUS    out  2  00 IDLE, 01 PLAY, 10 CRASH
//  SC_ROADSCHED_level_OutBUS    out  4  current level, saturates at 15
// BEHAVIOUR
//  Reset (async, immediate, no clock needed):
//   - All rows = 0, state IDLE, crash 0, level 0.
//   - Prescaler 0, period TICK_INIT, row_cnt 0, lfsr LFSR_SEED, start_q 0.
//  Start edge: start_q follows start_In each clock; start_rise = start_In & ~start_q.
//   - Holding start high yields exactly one start_rise.
//  Init action (on any start_rise that changes state):
//   - Rows 0, prescaler 0, period TICK_INIT, row_cnt 0, level 0, lfsr LFSR_SEED.
//  IDLE: rows held at 0. start_rise -> PLAY with init action; state 01 visible next clock.
//  PLAY: prescaler increments every clock. When prescaler == period-1, this is a tick:
//   - Prescaler returns to 0.
//   - Crash check uses pre-shift data6: if (data6 & player) != 0 -> CRASH.
//     No shift, no level update, crash_Out 1 the next clock.
//   - Otherwise, shift down: data6<=data5, ..., data1<=data0.
//     data0 <= (row_cnt[0]==0) ? (8'h01 << lfsr[2:0]) : 8'h00.
//     Obstacles are single-bit, so a free lane always exists.
//   - lfsr advances on every non-crash tick: shift left, bit0 = l7^l5^l4^l3.
//   - row_cnt increments; at ROWS_PER_LEVEL-1 it wraps to 0 and level increments (sat. 15).
//     Period becomes max(period-TICK_STEP, TICK_MIN); no unsigned underflow.
//   - Lateral player motion between ticks is never a crash.
//   - start_rise in PLAY is ignored.
//  CRASH: rows, level and prescaler frozen; crash_Out 1.
//   - start_rise -> PLAY with init action; crash_Out 0 on the same edge.
//  Precedence: reset > crash > level update.
//  Latency: player input to crash decision is combinational at the tick edge; outputs are registered.
// STRUCTURE
//  Shared package: state encodings (IDLE/PLAY/CRASH), LFSR taps and default seed, row count 7.
//  Sub-module sc_lfsr8: enable, load-seed, 8-bit output.
//  Top: FSM, prescaler/period registers, row shift bank, level counter.
// TESTING
//  Parameters for 2-6: TICK_INIT=4, TICK_STEP=1, TICK_MIN=2, ROWS_PER_LEVEL=4.
//  1 Reset asserted -> all data* 0, state 00, crash 0, level 0; no clock edge needed.
//  2 start 0->1, player 8'h00 -> state 01 next clock.
//    Tick 4 clocks later: data0=8'h20 (seed A5, bits[2:0]=5). Next tick: data0=0, data1=8'h20.
//  3 player=8'h80 fixed, data6 == 8'h80 at a tick -> crash_Out 1, state 10.
//    Rows unchanged for 20 further clocks.
//    Then a start pulse -> state 01, all rows 0, level 0.
//  4 Run without crash for 4 ticks -> level 1, tick spacing 3 clocks.
//    8 ticks -> level 2, spacing 2. 12 ticks -> level 3, spacing stays 2 (TICK_MIN floor).
//  5 start held high through IDLE->PLAY, then pulsed again in PLAY -> no restart.
//    Rows and level keep evolving.
//  6 Reset asserted mid-PLAY between clock edges -> outputs 0 immediately.
//    After release, state stays 00 until a new start_rise.

Source files
------------

// File: rtl/sc_road_scheduler_pkg.sv
// Shared definitions for the Road Fighter row scheduler: FSM states, LFSR taps/seed,
// and the number of obstacle rows driven onto the matrix.
package sc_road_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_CRASH = 2'b10
  } state_t;

  localparam int unsigned ROW_COUNT         = 7;
  localparam logic [7:0]  LFSR_TAPS         = 8'hB8;  // bits 7,5,4,3
  localparam logic [7:0]  LFSR_SEED_DEFAULT = 8'hA5;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sc_road_scheduler_if.sv
// Player/matrix-side bundle of the road scheduler: start button, player row in,
// obstacle rows and status out.
interface sc_road_scheduler_if #(
  parameter int unsigned DATAWIDTH_BUS = 8
);
  logic                     SC_ROADSCHED_start_In;
  logic [DATAWIDTH_BUS-1:0] SC_ROADSCHED_player_InBUS;
  logic [DATAWIDTH_BUS-1:0] SC_ROADSCHED_data0_OutBUS;
  logic [DATAWIDTH_BUS-1:0] SC_ROADSCHED_data1_OutBUS;
  logic [DATAWIDTH_BUS-1:0] SC_ROADSCHED_data2_OutBUS;
  logic [DATAWIDTH_BUS-1:0] SC_ROADSCHED_data3_OutBUS;
  logic [DATAWIDTH_BUS-1:0] SC_ROADSCHED_data4_OutBUS;
  logic [DATAWIDTH_BUS-1:0] SC_ROADSCHED_data5_OutBUS;
  logic [DATAWIDTH_BUS-1:0] SC_ROADSCHED_data6_OutBUS;
  logic                     SC_ROADSCHED_crash_Out;
  logic [1:0]               SC_ROADSCHED_state_OutBUS;
  logic [3:0]               SC_ROADSCHED_level_OutBUS;

  modport slave (
    input  SC_ROADSCHED_start_In, SC_ROADSCHED_player_InBUS,
    output SC_ROADSCHED_data0_OutBUS, SC_ROADSCHED_data1_OutBUS, SC_ROADSCHED_data2_OutBUS,
           SC_ROADSCHED_data3_OutBUS, SC_ROADSCHED_data4_OutBUS, SC_ROADSCHED_data5_OutBUS,
           SC_ROADSCHED_data6_OutBUS, SC_ROADSCHED_crash_Out, SC_ROADSCHED_state_OutBUS,
           SC_ROADSCHED_level_OutBUS
  );

  modport master (
    output SC_ROADSCHED_start_In, SC_ROADSCHED_player_InBUS,
    input  SC_ROADSCHED_data0_OutBUS, SC_ROADSCHED_data1_OutBUS, SC_ROADSCHED_data2_OutBUS,
           SC_ROADSCHED_data3_OutBUS, SC_ROADSCHED_data4_OutBUS, SC_ROADSCHED_data5_OutBUS,
           SC_ROADSCHED_data6_OutBUS, SC_ROADSCHED_crash_Out, SC_ROADSCHED_state_OutBUS,
           SC_ROADSCHED_level_OutBUS
  );
endinterface

// File: rtl/sc_road_scheduler_lfsr8.sv
// 8-bit Fibonacci LFSR picking obstacle lanes; load restores the seed and wins over enable.
module sc_lfsr8
  import sc_road_scheduler_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  output logic [7:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       value <= SEED;
    else if (load) value <= SEED;
    else if (en)   value <= lfsr_next(value);
  end

endmodule

// File: rtl/sc_road_scheduler.sv
// Road Fighter sequencer: scrolls single-lane obstacle rows toward the player at a
// level-dependent rate and freezes the field on a collision.
module sc_road_scheduler
  import sc_road_scheduler_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS       = 8,
  parameter int unsigned PRESCALER_DATAWIDTH = 23,
  parameter int unsigned TICK_INIT           = 5000000,
  parameter int unsigned TICK_MIN            = 1000000,
  parameter int unsigned TICK_STEP           = 500000,
  parameter int unsigned ROWS_PER_LEVEL      = 16,
  parameter logic [7:0]  LFSR_SEED           = 8'hA5
) (
  input  logic                SC_ROADSCHED_CLOCK_50,
  input  logic                SC_ROADSCHED_RESET_InHigh,
  sc_road_scheduler_if.slave  road
);

  localparam int unsigned PW          = PRESCALER_DATAWIDTH;
  localparam int unsigned DW          = DATAWIDTH_BUS;
  localparam int unsigned STEP_FLOOR  = TICK_MIN + TICK_STEP;
  localparam logic [15:0] ROW_WRAP    = 16'(ROWS_PER_LEVEL - 1);
  localparam logic [7:0]  LANE_MASK   = 8'h07;

  logic          clk, rst;
  state_t        state, state_nxt;
  logic          start_q, start_rise, init, tick, hit;
  logic [PW-1:0] presc, period, period_dn;
  logic [15:0]   row_cnt;
  logic [3:0]    level;
  logic [7:0]    lfsr;
  logic [DW-1:0] obstacle;
  logic [DW-1:0] rows [ROW_COUNT];

  assign clk        = SC_ROADSCHED_CLOCK_50;
  assign rst        = SC_ROADSCHED_RESET_InHigh;
  assign start_rise = road.SC_ROADSCHED_start_In & ~start_q;
  assign init       = start_rise && (state != ST_PLAY);
  assign tick       = (state == ST_PLAY) && (presc == period - PW'(1));
  assign hit        = |(rows[ROW_COUNT-1] & road.SC_ROADSCHED_player_InBUS);
  assign obstacle   = DW'(1) << (lfsr & LANE_MASK);

  always_comb begin
    if (32'(period) >= STEP_FLOOR) period_dn = period - PW'(TICK_STEP);
    else                           period_dn = PW'(TICK_MIN);
  end

  sc_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (init),
    .en    (tick && !hit),
    .value (lfsr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_rise)  state_nxt = ST_PLAY;
      ST_PLAY:  if (tick && hit) state_nxt = ST_CRASH;
      ST_CRASH: if (start_rise)  state_nxt = ST_PLAY;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    road.SC_ROADSCHED_crash_Out    = (state == ST_CRASH);
    road.SC_ROADSCHED_state_OutBUS = state;
    road.SC_ROADSCHED_level_OutBUS = level;
  end

  // A crash tick only rewinds the prescaler; rows, row count, level and period hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      presc   <= '0;
      period  <= PW'(TICK_INIT);
      row_cnt <= '0;
      level   <= '0;
      for (int unsigned i = 0; i < ROW_COUNT; i++) rows[i] <= '0;
    end else begin
      start_q <= road.SC_ROADSCHED_start_In;
      if (init) begin
        presc   <= '0;
        period  <= PW'(TICK_INIT);
        row_cnt <= '0;
        level   <= '0;
        for (int unsigned i = 0; i < ROW_COUNT; i++) rows[i] <= '0;
      end else if (state == ST_PLAY) begin
        if (!tick) begin
          presc <= presc + PW'(1);
        end else begin
          presc <= '0;
          if (!hit) begin
            for (int unsigned i = ROW_COUNT - 1; i > 0; i--) rows[i] <= rows[i-1];
            rows[0] <= row_cnt[0] ? '0 : obstacle;
            if (row_cnt == ROW_WRAP) begin
              row_cnt <= '0;
              period  <= period_dn;
              if (level != 4'hF) level <= level + 4'd1;
            end else begin
              row_cnt <= row_cnt + 16'd1;
            end
          end
        end
      end
    end
  end

  assign road.SC_ROADSCHED_data0_OutBUS = rows[0];
  assign road.SC_ROADSCHED_data1_OutBUS = rows[1];
  assign road.SC_ROADSCHED_data2_OutBUS = rows[2];
  assign road.SC_ROADSCHED_data3_OutBUS = rows[3];
  assign road.SC_ROADSCHED_data4_OutBUS = rows[4];
  assign road.SC_ROADSCHED_data5_OutBUS = rows[5];
  assign road.SC_ROADSCHED_data6_OutBUS = rows[6];

endmodule

// File: tb/tb_sc_road_scheduler.sv
// Bench for sc_road_scheduler: directed scenarios with hand-computed values plus a
// randomized run checked every cycle against a tick-counting game model.
module tb_sc_road_scheduler;

  localparam int T_INIT = 4;
  localparam int T_STEP = 1;
  localparam int T_MIN  = 2;
  localparam int RPL    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [7:0] player = 8'h00;
  logic chk_en = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  sc_road_scheduler_if #(.DATAWIDTH_BUS(8)) road ();

  assign road.SC_ROADSCHED_start_In     = start;
  assign road.SC_ROADSCHED_player_InBUS = player;

  sc_road_scheduler #(
    .DATAWIDTH_BUS       (8),
    .PRESCALER_DATAWIDTH (23),
    .TICK_INIT           (T_INIT),
    .TICK_MIN            (T_MIN),
    .TICK_STEP           (T_STEP),
    .ROWS_PER_LEVEL      (RPL),
    .LFSR_SEED           (8'hA5)
  ) dut (
    .SC_ROADSCHED_CLOCK_50     (clk),
    .SC_ROADSCHED_RESET_InHigh (rst),
    .road                      (road)
  );

  always #5 clk = ~clk;

  logic [62:0] dut_vec;
  logic [55:0] dut_rows;
  assign dut_rows = {road.SC_ROADSCHED_data0_OutBUS, road.SC_ROADSCHED_data1_OutBUS,
                     road.SC_ROADSCHED_data2_OutBUS, road.SC_ROADSCHED_data3_OutBUS,
                     road.SC_ROADSCHED_data4_OutBUS, road.SC_ROADSCHED_data5_OutBUS,
                     road.SC_ROADSCHED_data6_OutBUS};
  assign dut_vec = {dut_rows, road.SC_ROADSCHED_crash_Out,
                    road.SC_ROADSCHED_state_OutBUS, road.SC_ROADSCHED_level_OutBUS};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: 0 idle, 1 play, 2 crash; scroll timing derived from ticks survived.
  int         m_state = 0;
  logic [7:0] m_rows [7];
  int         m_cnt = 0;
  int         m_ticks = 0;
  bit         m_sq = 1'b0;
  logic [7:0] m_lfsr = 8'hA5;

  function automatic int period_of(input int t);
    int p;
    p = T_INIT - (t / RPL) * T_STEP;
    if (p < T_MIN) p = T_MIN;
    return p;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [62:0] model_vec();
    logic [55:0] r;
    int lv;
    r = {m_rows[0], m_rows[1], m_rows[2], m_rows[3], m_rows[4], m_rows[5], m_rows[6]};
    lv = m_ticks / RPL;
    if (lv > 15) lv = 15;
    return {r, (m_state == 2), 2'(m_state), 4'(lv)};
  endfunction

  task automatic m_init();
    for (int i = 0; i < 7; i++) m_rows[i] = 8'h00;
    m_cnt = 0;
    m_ticks = 0;
    m_lfsr = 8'hA5;
  endtask

  always @(posedge clk or posedge rst) begin
    bit rise;
    logic [7:0] one;
    if (rst) begin
      m_state = 0;
      m_sq = 1'b0;
      m_init();
    end else begin
      rise = start && !m_sq;
      m_sq = start;
      if (m_state != 1) begin
        if (rise) begin
          m_init();
          m_state = 1;
        end
      end else begin
        m_cnt++;
        if (m_cnt == period_of(m_ticks)) begin
          m_cnt = 0;
          if ((m_rows[6] & player) != 8'h00) begin
            m_state = 2;
          end else begin
            for (int i = 6; i > 0; i--) m_rows[i] = m_rows[i-1];
            one = 8'h01;
            m_rows[0] = (m_ticks % 2 == 0) ? (one << m_lfsr[2:0]) : 8'h00;
            m_lfsr = lfsr_step(m_lfsr);
            m_ticks++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) chk("cycle", 64'(dut_vec), 64'(model_vec()));
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int r;
    logic [7:0] one;

    #1 rst = 1'b1;
    #1;
    chk("reset_rows",  64'(dut_rows), 64'h0);
    chk("reset_state", 64'(road.SC_ROADSCHED_state_OutBUS), 64'h0);
    chk("reset_crash", 64'(road.SC_ROADSCHED_crash_Out), 64'h0);
    chk("reset_level", 64'(road.SC_ROADSCHED_level_OutBUS), 64'h0);
    @(negedge clk);
    chk_en = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    // first obstacle lands in lane 5 from seed A5, scrolls one row per tick
    start = 1'b1;
    player = 8'h00;
    @(negedge clk);
    chk("start_state", 64'(road.SC_ROADSCHED_state_OutBUS), 64'h1);
    repeat (4) @(negedge clk);
    chk("tick1_data0", 64'(road.SC_ROADSCHED_data0_OutBUS), 64'h20);
    repeat (4) @(negedge clk);
    chk("tick2_data0", 64'(road.SC_ROADSCHED_data0_OutBUS), 64'h00);
    chk("tick2_data1", 64'(road.SC_ROADSCHED_data1_OutBUS), 64'h20);

    // that obstacle reaches row 6 at tick 7 and hits on tick 8 (edge 28)
    player = 8'h20;
    n = 8;
    while (!road.SC_ROADSCHED_crash_Out && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("crash_edge",  64'(n), 64'd28);
    chk("crash_state", 64'(road.SC_ROADSCHED_state_OutBUS), 64'h2);
    chk("crash_level", 64'(road.SC_ROADSCHED_level_OutBUS), 64'h1);
    chk("crash_data6", 64'(road.SC_ROADSCHED_data6_OutBUS), 64'h20);
    repeat (20) @(negedge clk);
    chk("frozen_data6", 64'(road.SC_ROADSCHED_data6_OutBUS), 64'h20);
    chk("frozen_crash", 64'(road.SC_ROADSCHED_crash_Out), 64'h1);

    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    player = 8'h00;
    @(negedge clk);
    chk("restart_state", 64'(road.SC_ROADSCHED_state_OutBUS), 64'h1);
    chk("restart_rows",  64'(dut_rows), 64'h0);
    chk("restart_level", 64'(road.SC_ROADSCHED_level_OutBUS), 64'h0);
    chk("restart_crash", 64'(road.SC_ROADSCHED_crash_Out), 64'h0);

    // level thresholds: ticks at 4,8,12,16 | 19,22,25,28 | 30,32,34,36
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 10) start = 1'b0;
      if (k == 12) start = 1'b1;
      if (k == 15) chk("lvl0_edge15", 64'(road.SC_ROADSCHED_level_OutBUS), 64'h0);
      if (k == 16) chk("lvl1_edge16", 64'(road.SC_ROADSCHED_level_OutBUS), 64'h1);
      if (k == 28) chk("lvl2_edge28", 64'(road.SC_ROADSCHED_level_OutBUS), 64'h2);
      if (k == 34) chk("lvl2_edge34", 64'(road.SC_ROADSCHED_level_OutBUS), 64'h2);
      if (k == 36) chk("lvl3_edge36", 64'(road.SC_ROADSCHED_level_OutBUS), 64'h3);
    end
    repeat (170) @(negedge clk);
    chk("level_saturated", 64'(road.SC_ROADSCHED_level_OutBUS), 64'hF);

    #2 rst = 1'b1;
    #1;
    chk("midplay_reset", 64'(dut_vec), 64'h0);
    @(negedge clk);
    start = 1'b0;
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_after_reset", 64'(road.SC_ROADSCHED_state_OutBUS), 64'h0);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 4) begin
        start = ~start;
      end else if (r < 14) begin
        one = 8'h01;
        player = ($urandom_range(0, 1) == 0) ? 8'h00 : (one << $urandom_range(0, 7));
      end else if (r == 99 && $urandom_range(0, 9) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
